// File: rtl/custom_wptr_full_sync.sv
// Write-domain half of the dual-clock FIFO: brings the Gray read pointer across with
// two flops, advances the write pointer and derives full, almost-full, count and overflow.
module custom_wptr_full_sync #(
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_THRESH = (1 << ADDRSIZE) - 2
) (
    input  logic                wclk_i,
    input  logic                wrst_n_i,
    input  logic                winc_i,
    input  logic [ADDRSIZE:0]   rptr_g,
    output logic                wen_o,
    output logic [ADDRSIZE-1:0] waddr_o,
    output logic [ADDRSIZE:0]   wptr_g,
    output logic                wfull_o,
    output logic                walmost_full_o,
    output logic [ADDRSIZE:0]   wcount_o,
    output logic                woverflow_o
);

    localparam logic [ADDRSIZE:0] AFULL_W = (ADDRSIZE+1)'(AFULL_THRESH);

    logic [ADDRSIZE:0] rq1;
    logic [ADDRSIZE:0] rq2;
    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wbin_next;
    logic [ADDRSIZE:0] wgray_next;
    logic [ADDRSIZE:0] wocc_next;
    logic              wacc;
    logic              wfull_next;

    always_comb begin
        rbin = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            rbin[i] = ^(rq2 >> i);
        end
    end

    assign wacc       = winc_i & ~wfull_o;
    assign wen_o      = wacc;
    assign waddr_o    = wbin[ADDRSIZE-1:0];
    assign wbin_next  = wbin + (ADDRSIZE+1)'(wacc);
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;
    assign wocc_next  = wbin_next - rbin;

    // Writer exactly one lap ahead: the two top Gray bits differ, the rest match.
    assign wfull_next = (wgray_next == {~rq2[ADDRSIZE:ADDRSIZE-1], rq2[ADDRSIZE-2:0]});

    always_ff @(posedge wclk_i) begin
        if (!wrst_n_i) begin
            rq1            <= '0;
            rq2            <= '0;
            wbin           <= '0;
            wptr_g         <= '0;
            wfull_o        <= 1'b0;
            walmost_full_o <= 1'b0;
            wcount_o       <= '0;
            woverflow_o    <= 1'b0;
        end else begin
            rq1            <= rptr_g;
            rq2            <= rq1;
            wbin           <= wbin_next;
            wptr_g         <= wgray_next;
            wfull_o        <= wfull_next;
            walmost_full_o <= (wocc_next >= AFULL_W);
            wcount_o       <= wocc_next;
            woverflow_o    <= woverflow_o | (winc_i & wfull_o);
        end
    end

endmodule

// File: tb/tb_custom_wptr_full_sync.sv
// Bench for custom_wptr_full_sync: directed scenarios plus randomized traffic, checked
// against an occupancy-based reference model of the write side.
module tb_custom_wptr_full_sync;

    localparam int A     = 4;
    localparam int DEPTH = 1 << A;
    localparam int PMOD  = 2 * DEPTH;
    localparam int THR   = 14;

    logic         wclk_i = 1'b0;
    logic         wrst_n_i = 1'b0;
    logic         winc_i = 1'b0;
    logic [A:0]   rptr_g = '0;
    logic         wen_o;
    logic [A-1:0] waddr_o;
    logic [A:0]   wptr_g;
    logic         wfull_o;
    logic         walmost_full_o;
    logic [A:0]   wcount_o;
    logic         woverflow_o;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state: write position, raw Gray samples in the two sync stages
    int m_wr = 0;
    int m_s1 = 0;
    int m_s2 = 0;
    int m_cnt = 0;
    bit m_full = 0;
    bit m_af = 0;
    bit m_ovf = 0;
    bit m_valid = 0;
    int rd = 0;

    custom_wptr_full_sync #(.ADDRSIZE(A), .AFULL_THRESH(THR)) dut (
        .wclk_i(wclk_i), .wrst_n_i(wrst_n_i), .winc_i(winc_i), .rptr_g(rptr_g),
        .wen_o(wen_o), .waddr_o(waddr_o), .wptr_g(wptr_g), .wfull_o(wfull_o),
        .walmost_full_o(walmost_full_o), .wcount_o(wcount_o), .woverflow_o(woverflow_o)
    );

    always #5 wclk_i = ~wclk_i;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int to_gray(input int b);
        return (b ^ (b >> 1)) % PMOD;
    endfunction

    function automatic int from_gray(input int g);
        int b = 0;
        for (int i = 0; i <= A; i++) b |= (^(g >> i)) << i;
        return b;
    endfunction

    task automatic model_edge(input bit rstn, input bit winc, input int rg);
        int wr_n, occ;
        if (!rstn) begin
            m_wr = 0; m_s1 = 0; m_s2 = 0; m_cnt = 0;
            m_full = 0; m_af = 0; m_ovf = 0;
        end else begin
            wr_n  = (m_wr + ((winc && !m_full) ? 1 : 0)) % PMOD;
            occ   = (wr_n - from_gray(m_s2) + PMOD) % PMOD;
            m_ovf = m_ovf | (winc && m_full);
            m_full = (occ == DEPTH);
            m_af  = (occ >= THR);
            m_cnt = occ;
            m_wr  = wr_n;
            m_s2  = m_s1;
            m_s1  = rg;
        end
        m_valid = 1;
    endtask

    task automatic tick();
        bit rstn, winc;
        int rg;
        #1;
        if (m_valid) chk("wen", wen_o, (winc_i && !m_full) ? 1 : 0);
        @(posedge wclk_i);
        rstn = wrst_n_i; winc = winc_i; rg = rptr_g;
        model_edge(rstn, winc, rg);
        #1;
        chk("wfull", wfull_o, m_full);
        chk("walmost_full", walmost_full_o, m_af);
        chk("wcount", wcount_o, m_cnt);
        chk("woverflow", woverflow_o, m_ovf);
        chk("waddr", waddr_o, m_wr % DEPTH);
        chk("wptr_g", wptr_g, to_gray(m_wr));
    endtask

    task automatic do_reset(input int edges);
        wrst_n_i = 0; winc_i = 0; rptr_g = '0; rd = 0;
        repeat (edges) tick();
        wrst_n_i = 1;
    endtask

    initial begin
        // reset with writes requested and a nonzero read pointer
        wrst_n_i = 0; winc_i = 1; rptr_g = 5'h1F;
        repeat (2) tick();
        chk("rst_wptr", wptr_g, 0);
        chk("rst_count", wcount_o, 0);
        chk("rst_ovf", woverflow_o, 0);
        wrst_n_i = 1; winc_i = 0;
        repeat (3) tick();
        chk("rst_rq2_count", wcount_o, (0 - 21 + PMOD) % PMOD);

        // fill from empty
        do_reset(2);
        for (int i = 1; i <= DEPTH; i++) begin
            winc_i = 1;
            tick();
            if (i == THR - 1) chk("af_before_thr", walmost_full_o, 0);
            if (i == THR) chk("af_at_thr", walmost_full_o, 1);
            if (i == DEPTH - 1) chk("full_before_last", wfull_o, 0);
        end
        chk("fill_full", wfull_o, 1);
        chk("fill_waddr", waddr_o, 0);
        chk("fill_wptr", wptr_g, 5'h18);
        chk("fill_count", wcount_o, 16);

        // writes while full are dropped
        for (int i = 0; i < 3; i++) begin
            winc_i = 1;
            #1 chk("ovf_wen", wen_o, 0);
            tick();
            chk("ovf_wptr_hold", wptr_g, 5'h18);
            chk("ovf_flag", woverflow_o, 1);
        end
        winc_i = 0;

        // read advance releases full after exactly three edges
        rptr_g = 5'h01;
        tick(); tick();
        chk("rel_full_2edges", wfull_o, 1);
        tick();
        chk("rel_full_3edges", wfull_o, 0);
        chk("rel_count15", wcount_o, 15);
        chk("rel_af15", walmost_full_o, 1);
        rptr_g = 5'h03;
        repeat (3) tick();
        chk("rel_count14", wcount_o, 14);
        rptr_g = 5'h02;
        repeat (3) tick();
        chk("rel_count13", wcount_o, 13);
        chk("rel_af13", walmost_full_o, 0);
        rptr_g = 5'(to_gray(16));
        repeat (3) tick();
        chk("drain_count", wcount_o, 0);
        chk("drain_ovf_sticky", woverflow_o, 1);

        // continuous writes with the reader tracking the write pointer
        do_reset(1);
        for (int i = 0; i < 40; i++) begin
            winc_i = 1;
            rptr_g = 5'(to_gray(m_wr));
            tick();
            chk("wrap_never_full", wfull_o, 0);
            chk("wrap_count_le3", (wcount_o <= 3) ? 1 : 0, 1);
        end
        winc_i = 0;

        // reset in the middle of a burst
        do_reset(1);
        for (int i = 0; i < 10; i++) begin winc_i = 1; tick(); end
        chk("mid_count10", wcount_o, 10);
        wrst_n_i = 0; winc_i = 1;
        tick();
        chk("mid_waddr", waddr_o, 0);
        chk("mid_count", wcount_o, 0);
        chk("mid_full", wfull_o, 0);
        wrst_n_i = 1; winc_i = 1;
        #1 chk("mid_resume_addr", waddr_o, 0);
        chk("mid_resume_wen", wen_o, 1);
        tick();
        chk("mid_resume_next", waddr_o, 1);

        // randomized traffic with occasional resets
        rd = 0; rptr_g = '0;
        for (int blk = 0; blk < 8; blk++) begin
            int wprob, rprob;
            wprob = $urandom_range(20, 95);
            rprob = $urandom_range(20, 95);
            for (int c = 0; c < 200; c++) begin
                wrst_n_i = ($urandom_range(0, 299) != 0);
                winc_i   = ($urandom_range(0, 99) < wprob);
                if (!wrst_n_i) rd = 0;
                else if (($urandom_range(0, 99) < rprob) && (((m_wr - rd + PMOD) % PMOD) != 0))
                    rd = (rd + 1) % PMOD;
                rptr_g = 5'(to_gray(rd));
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
